// File: rtl/fmrv32im_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmrv32im_pkg
// Description : Shared definitions for the RV32M iterative divider:
//               FSM state encoding, iteration count and the fixed
//               fast-path result constants.
// Revision    : 1.0 - initial release
// ============================================================================
package fmrv32im_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_FINISH = 2'd2
    } div_state_t;

    localparam int          DIV_ITER      = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/fmrv32im_udiv_step.sv
`default_nettype none
// ============================================================================
// Module      : fmrv32im_udiv_step
// Description : One combinational radix-2 restoring division step.
//               The partial remainder is shifted left with the next dividend
//               bit appended; if it is not below the divisor the divisor is
//               subtracted and the quotient bit is 1.
// Ports       : rem_in       - 33-bit partial remainder from previous step
//               divisor      - 32-bit divisor magnitude
//               dividend_bit - next dividend bit (MSB first)
//               rem_out      - 33-bit partial remainder after this step
//               q_bit        - quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module fmrv32im_udiv_step
    import fmrv32im_pkg::*;
(
    input  logic [32:0] rem_in,
    input  logic [31:0] divisor,
    input  logic        dividend_bit,
    output logic [32:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem_in[31:0], dividend_bit};
    assign diff    = shifted - {1'b0, divisor};

    // rem_in[32] is zero whenever the previous step left a remainder below
    // the divisor; folding it in keeps the step correct for any input.
    assign q_bit   = rem_in[32] | (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted;

endmodule
`default_nettype wire

// File: rtl/fmrv32im_div.sv
`default_nettype none
// ============================================================================
// Module      : fmrv32im_div
// Description : Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU.
//               Restoring radix-2 on magnitudes, 32 iterations, with
//               single-cycle fast paths for divide-by-zero and signed
//               overflow. Stalls the core through WAIT and pulses READY for
//               one cycle with the registered result on RD.
// Ports       : RST_N     - asynchronous active-low reset
//               CLK       - clock, rising edge
//               INST_DIV  - signed quotient request
//               INST_DIVU - unsigned quotient request
//               INST_REM  - signed remainder request
//               INST_REMU - unsigned remainder request
//               RS1       - dividend
//               RS2       - divisor
//               WAIT      - stall request to the core
//               READY     - one-cycle pulse, RD valid
//               RD        - result
// Revision    : 1.0 - initial release
// ============================================================================
module fmrv32im_div
    import fmrv32im_pkg::*;
(
    input  logic        RST_N,
    input  logic        CLK,
    input  logic        INST_DIV,
    input  logic        INST_DIVU,
    input  logic        INST_REM,
    input  logic        INST_REMU,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic        WAIT,
    output logic        READY,
    output logic [31:0] RD
);

    div_state_t  state;
    div_state_t  state_next;

    logic [4:0]  count;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [32:0] rem;
    logic [31:0] quot;
    logic        is_rem;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] rd_q;

    logic        inst_any;
    logic        inst_signed;
    logic        inst_rem;
    logic        div_zero;
    logic        div_ovf;
    logic        fast_path;
    logic        last_step;
    logic [31:0] rs1_mag;
    logic [31:0] rs2_mag;

    logic [32:0] step_rem;
    logic        step_q;
    logic [31:0] q_final;
    logic [31:0] r_final;
    logic [31:0] result;

    assign inst_any    = INST_DIV | INST_DIVU | INST_REM | INST_REMU;
    assign inst_signed = INST_DIV | INST_REM;
    assign inst_rem    = INST_REM | INST_REMU;

    assign div_zero    = (RS2 == 32'd0);
    assign div_ovf     = inst_signed & (RS1 == INT_MIN) & (RS2 == 32'hFFFF_FFFF);
    assign fast_path   = div_zero | div_ovf;

    // INT_MIN negates to itself, which is its correct unsigned magnitude.
    assign rs1_mag = (inst_signed & RS1[31]) ? -RS1 : RS1;
    assign rs2_mag = (inst_signed & RS2[31]) ? -RS2 : RS2;

    assign last_step = (count == 5'(DIV_ITER - 1));

    assign READY = (state == S_FINISH);
    assign WAIT  = inst_any & ~READY;
    assign RD    = rd_q;

    fmrv32im_udiv_step u_step (
        .rem_in       (rem),
        .divisor      (divisor),
        .dividend_bit (dividend[31]),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Result of the final iteration, sign-corrected, so RD is already
    // valid in the FINISH cycle.
    assign q_final = {quot[30:0], step_q};
    assign r_final = step_rem[31:0];
    assign result  = is_rem ? (neg_r ? -r_final : r_final)
                            : (neg_q ? -q_final : q_final);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (inst_any) begin
                    state_next = fast_path ? S_FINISH : S_EXEC;
                end
            end
            S_EXEC: begin
                if (last_step) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count    <= 5'd0;
            dividend <= 32'd0;
            divisor  <= 32'd0;
            rem      <= 33'd0;
            quot     <= 32'd0;
            is_rem   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rd_q     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inst_any) begin
                        count    <= 5'd0;
                        dividend <= rs1_mag;
                        divisor  <= rs2_mag;
                        rem      <= 33'd0;
                        quot     <= 32'd0;
                        is_rem   <= inst_rem;
                        neg_q    <= inst_signed & (RS1[31] ^ RS2[31]);
                        neg_r    <= inst_signed & RS1[31];
                        // Fast-path results are architecturally fixed and
                        // bypass sign correction.
                        if (div_zero) begin
                            rd_q <= inst_rem ? RS1 : DIV_BY_ZERO_Q;
                        end else if (div_ovf) begin
                            rd_q <= inst_rem ? 32'd0 : INT_MIN;
                        end
                    end
                end
                S_EXEC: begin
                    count    <= count + 5'd1;
                    dividend <= {dividend[30:0], 1'b0};
                    rem      <= step_rem;
                    quot     <= q_final;
                    if (last_step) begin
                        rd_q <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/fmrv32im_div.md
# fmrv32im_div

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the division counterpart to the single-cycle multiplier and sits beside it in the execute stage. Unlike the multiplier, it stalls the core through WAIT for the full iteration and signals completion with a one-cycle READY pulse carrying RD. It uses a radix-2 restoring algorithm on magnitudes, with fast paths for divide-by-zero and signed overflow.

## Interface
Parameters: none (iteration count fixed at 32).

- RST_N  in  1  asynchronous active-low reset
- CLK  in  1  clock, rising edge
- INST_DIV  in  1  signed quotient request
- INST_DIVU  in  1  unsigned quotient request
- INST_REM  in  1  signed remainder request
- INST_REMU  in  1  unsigned remainder request
- RS1  in  32  dividend
- RS2  in  32  divisor
- WAIT  out  1  stall request to the core
- READY  out  1  one-cycle pulse: RD valid
- RD  out  32  result

One clock; reset is asynchronous and active-low.

## Operation
- At most one INST_* is high at a time. Let inst_any be the OR of all four.
- The core holds INST_* and RS1/RS2 stable from first assertion until the cycle READY is high. It drops INST_* the cycle after READY.
- WAIT = inst_any & ~READY (combinational).
- FSM states are IDLE, EXEC and FINISH.
- **IDLE**, when inst_any is high, latches the following:
  - op (quotient or remainder), signed flag (DIV/REM).
  - |RS1| and |RS2| when signed, else raw values.
  - neg_q = signed & (RS1[31]^RS2[31]).
  - neg_r = signed & RS1[31].
- **IDLE transitions:**
  - RS2 == 0 → FINISH. Quotient = 0xFFFFFFFF, remainder = RS1.
  - signed & RS1 == 0x80000000 & RS2 == 0xFFFFFFFF → FINISH. Quotient = 0x80000000, remainder = 0.
  - Otherwise → EXEC with count = 0.
- **EXEC** performs one restoring step per cycle. Width rules:
  - The partial remainder is 33 bits, shifted left with the next dividend MSB appended.
  - If partial remainder ≥ {1'b0, divisor}: subtract, and the quotient bit is 1.
  - The quotient shifts in from the LSB.
  - After the 32nd step (count == 31), go to FINISH.
- **FINISH:**
  - RD = selected quotient or remainder, negated (two's complement) if neg_q or neg_r respectively.
  - Fast-path results are not negated.
  - READY = 1, then → IDLE.
- RD is registered and holds its last value until the next FINISH.
- An INST_* asserted in the cycle after FINISH (in IDLE) starts a new operation. Back-to-back operation has no dead cycle beyond the IDLE accept cycle.

## Timing
- Reset values: state IDLE, READY 0, RD 0x00000000, all internal registers 0. WAIT follows inst_any immediately.
- Let T be the first cycle with inst_any high in IDLE.
- Normal path:
  - EXEC occupies T+1..T+32.
  - READY is high at T+33.
  - WAIT is high T..T+32 and low at T+33.
- Fast path: READY at T+1, WAIT high only at T.
- Reset mid-operation: the FSM returns to IDLE asynchronously with no READY and RD = 0. An instruction still held after reset release restarts from IDLE.
- If inst_any deasserts during EXEC (a core protocol violation), the operation still completes and pulses READY. The result is discarded by the core.

## Structure
- Shared package fmrv32im_pkg holds:
  - state encoding (S_IDLE=2'd0, S_EXEC=2'd1, S_FINISH=2'd2).
  - DIV_ITER = 32.
  - DIV_BY_ZERO_Q = 32'hFFFFFFFF.
  - INT_MIN = 32'h80000000.
- One sub-module is natural: fmrv32im_udiv_step, a combinational single restoring step.
  - Inputs: 33-bit partial remainder, 32-bit divisor, dividend bit.
  - Outputs: next remainder, quotient bit.
- Top level holds the FSM, counter, sign handling and output register.

## Test plan
- DIVU RS1=100, RS2=7 → RD=14, READY exactly at T+33, WAIT high for 33 cycles; REMU same operands → RD=2.
- DIV RS1=0xFFFFFFF9 (-7), RS2=2 → RD=0xFFFFFFFD (-3); REM → RD=0xFFFFFFFF (-1); REM RS1=7, RS2=0xFFFFFFFE → RD=1.
- DIVU RS1=0x12345678, RS2=0 → RD=0xFFFFFFFF at T+1; REMU → RD=0x12345678 at T+1.
- DIV RS1=0x80000000, RS2=0xFFFFFFFF → RD=0x80000000 at T+1; REM → RD=0.
- Start DIVU 1000/3, pull RST_N low at T+10 → READY 0, RD 0, no pulse. After release, DIVU 9/3 → RD=3 at T'+33.
- Back-to-back DIVU 0xFFFFFFFF/1 then REMU 0xFFFFFFFF/0x10 → RD=0xFFFFFFFF then RD=0xF, two distinct READY pulses, no extra stall cycles.
